interrupt_sequencer: RTL and testbench

Multi-cycle controller that sequences interrupt entry and RTI return around the execute/memory pipeline. On an interrupt it drains in-flight memory operations, stalls fetch, and pushes the 32-bit resume PC and the 3-bit flags onto the stack as 16-bit words. It then redirects the PC to the interrupt vector. On RTI it pops the words back in reverse order, restores the flag register and reloads the PC. It sits beside the decode/execute boundary and borrows the execute stage's push/pop memory path while it is busy.

---
 rtl/interrupt_sequencer_pkg.sv | 29 ++
 rtl/interrupt_sequencer_int_pending_latch.sv | 26 ++
 rtl/interrupt_sequencer.sv | 157 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and widths for the interrupt entry / RTI return sequencer.
package interrupt_sequencer_pkg;

  localparam int FLAG_W = 3;
  localparam int WORD_W = 16;
  localparam int PC_W   = 2 * WORD_W;

  localparam logic [PC_W-1:0] DEFAULT_INT_VECTOR = 32'h0000_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DRAIN_I,
    S_PUSH_HI,
    S_PUSH_LO,
    S_PUSH_FL,
    S_VECTOR,
    S_DRAIN_R,
    S_POP_FL,
    S_POP_LO,
    S_POP_HI,
    S_RESUME
  } state_t;

  // Flags travel through the stack zero-extended to a full word.
  function automatic logic [WORD_W-1:0] flags_to_word(input logic [FLAG_W-1:0] f);
    return {{(WORD_W - FLAG_W){1'b0}}, f};
  endfunction

endpackage

// File: rtl/interrupt_sequencer_int_pending_latch.sv
// Rising-edge detector on int_req feeding a set/clear pending flop.
// A set and a clear in the same cycle leave pending set so no edge is lost.
module int_pending_latch (
  input  logic clk,
  input  logic reset,
  input  logic int_req,
  input  logic clear,
  output logic pending
);

  logic int_req_q;
  logic rise;

  assign rise = int_req & ~int_req_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_req_q <= 1'b0;
      pending   <= 1'b0;
    end else begin
      int_req_q <= int_req;
      pending   <= rise | (pending & ~clear);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Sequences interrupt entry (drain, push PC/flags, vector) and RTI return
// (drain, pop flags/PC, resume) while borrowing the execute stage stack path.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | pipeline runs normally; watches pending / rti_decoded
//   S_DRAIN_I | interrupt: wait for EX/MEM memory ops, then capture flags
//   S_PUSH_HI | push saved_pc[31:16]
//   S_PUSH_LO | push saved_pc[15:0]
//   S_PUSH_FL | push zero-extended saved flags
//   S_VECTOR  | load PC with INT_VECTOR, acknowledge the interrupt
//   S_DRAIN_R | RTI: wait for EX/MEM memory ops
//   S_POP_FL  | pop flags word
//   S_POP_LO  | pop low PC half
//   S_POP_HI  | pop high PC half
//   S_RESUME  | reload PC and flag register from the popped words
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] INT_VECTOR = DEFAULT_INT_VECTOR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_req,
  input  logic              rti_decoded,
  input  logic              pipe_busy,
  input  logic [PC_W-1:0]   pc_next,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] pop_data,
  output logic              stall_fetch,
  output logic              flush_decode,
  output logic              mem_push,
  output logic              mem_pop,
  output logic [WORD_W-1:0] push_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_value,
  output logic              flags_restore_en,
  output logic [FLAG_W-1:0] flags_restore,
  output logic              int_ack,
  output logic              busy
);

  state_t              state;
  state_t              state_nxt;
  logic                pending;
  logic                pend_clear;
  logic                flush_q;
  logic [PC_W-1:0]     saved_pc;
  logic [FLAG_W-1:0]   saved_flags;
  logic [WORD_W-1:0]   pop_lo;
  logic [WORD_W-1:0]   pop_hi;

  int_pending_latch u_pend (
    .clk     (clk),
    .reset   (reset),
    .int_req (int_req),
    .clear   (pend_clear),
    .pending (pending)
  );

  // Pending is consumed exactly when IDLE commits to interrupt entry.
  assign pend_clear = (state == S_IDLE) && pending;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pending)          state_nxt = S_DRAIN_I;
        else if (rti_decoded) state_nxt = S_DRAIN_R;
      end
      S_DRAIN_I: if (!pipe_busy) state_nxt = S_PUSH_HI;
      S_PUSH_HI: if (mem_ready)  state_nxt = S_PUSH_LO;
      S_PUSH_LO: if (mem_ready)  state_nxt = S_PUSH_FL;
      S_PUSH_FL: if (mem_ready)  state_nxt = S_VECTOR;
      S_VECTOR:                  state_nxt = S_IDLE;
      S_DRAIN_R: if (!pipe_busy) state_nxt = S_POP_FL;
      S_POP_FL:  if (mem_ready)  state_nxt = S_POP_LO;
      S_POP_LO:  if (mem_ready)  state_nxt = S_POP_HI;
      S_POP_HI:  if (mem_ready)  state_nxt = S_RESUME;
      S_RESUME:                  state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      flush_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      flush_q <= (state == S_IDLE) && (state_nxt != S_IDLE);
    end
  end

  // Flags are taken on the last drain cycle so in-flight ALU updates land first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      saved_pc    <= '0;
      saved_flags <= '0;
      pop_lo      <= '0;
      pop_hi      <= '0;
    end else begin
      case (state)
        S_IDLE:    if (pending)    saved_pc    <= pc_next;
        S_DRAIN_I: if (!pipe_busy) saved_flags <= flags_in;
        S_POP_FL:  if (mem_ready)  saved_flags <= pop_data[FLAG_W-1:0];
        S_POP_LO:  if (mem_ready)  pop_lo      <= pop_data;
        S_POP_HI:  if (mem_ready)  pop_hi      <= pop_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy             = (state != S_IDLE);
    stall_fetch      = (state != S_IDLE);
    mem_push         = 1'b0;
    mem_pop          = 1'b0;
    push_data        = '0;
    pc_load          = 1'b0;
    pc_load_value    = '0;
    flags_restore_en = 1'b0;
    flags_restore    = '0;
    int_ack          = 1'b0;
    case (state)
      S_PUSH_HI: begin
        mem_push  = 1'b1;
        push_data = saved_pc[PC_W-1:WORD_W];
      end
      S_PUSH_LO: begin
        mem_push  = 1'b1;
        push_data = saved_pc[WORD_W-1:0];
      end
      S_PUSH_FL: begin
        mem_push  = 1'b1;
        push_data = flags_to_word(saved_flags);
      end
      S_VECTOR: begin
        pc_load       = 1'b1;
        pc_load_value = INT_VECTOR;
        int_ack       = 1'b1;
      end
      S_POP_FL, S_POP_LO, S_POP_HI: mem_pop = 1'b1;
      S_RESUME: begin
        pc_load          = 1'b1;
        pc_load_value    = {pop_hi, pop_lo};
        flags_restore_en = 1'b1;
        flags_restore    = saved_flags;
      end
      default: ;
    endcase
  end

  assign flush_decode = flush_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench: stimulus queues expected stack pushes and PC loads,
// a negedge monitor pops and compares them and checks per-cycle invariants.
module tb_interrupt_sequencer;

  localparam logic [31:0] VEC = 32'h0000_1F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req, rti_decoded, pipe_busy, mem_ready;
  logic [31:0] pc_next;
  logic [2:0]  flags_in;
  logic [15:0] pop_word;
  logic        stall_fetch, flush_decode, mem_push, mem_pop;
  logic [15:0] push_data;
  logic        pc_load, flags_restore_en, int_ack, busy;
  logic [31:0] pc_load_value;
  logic [2:0]  flags_restore;

  interrupt_sequencer #(.INT_VECTOR(VEC)) dut (
    .clk              (clk),
    .reset            (reset),
    .int_req          (int_req),
    .rti_decoded      (rti_decoded),
    .pipe_busy        (pipe_busy),
    .pc_next          (pc_next),
    .flags_in         (flags_in),
    .mem_ready        (mem_ready),
    .pop_data         (pop_word),
    .stall_fetch      (stall_fetch),
    .flush_decode     (flush_decode),
    .mem_push         (mem_push),
    .mem_pop          (mem_pop),
    .push_data        (push_data),
    .pc_load          (pc_load),
    .pc_load_value    (pc_load_value),
    .flags_restore_en (flags_restore_en),
    .flags_restore    (flags_restore),
    .int_ack          (int_ack),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        is_load;
    logic [31:0] val;
    logic        ack;
    logic        fen;
    logic [2:0]  fl;
  } ev_t;

  ev_t         sb[$];
  logic [15:0] pop_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ack_cyc = 0;
  int          load_cyc = 0;
  int          edge_cyc = 0;
  logic        rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic take_ev(input string name, input ev_t act);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: got unexpected event %h, none expected", name, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  // Reference: an interrupt pushes PC high, PC low, flags, then loads the vector.
  task automatic expect_int(input logic [31:0] pc, input logic [2:0] fl);
    sb.push_back('{1'b0, {16'h0, pc[31:16]}, 1'b0, 1'b0, 3'b0});
    sb.push_back('{1'b0, {16'h0, pc[15:0]},  1'b0, 1'b0, 3'b0});
    sb.push_back('{1'b0, {29'h0, fl},        1'b0, 1'b0, 3'b0});
    sb.push_back('{1'b1, VEC,                1'b1, 1'b0, 3'b0});
  endtask

  // Reference: RTI pops flags, PC low, PC high, then resumes at {hi,lo}.
  task automatic expect_rti(input logic [15:0] fw, input logic [15:0] lo, input logic [15:0] hi);
    pop_q.push_back(fw);
    pop_q.push_back(lo);
    pop_q.push_back(hi);
    sb.push_back('{1'b1, {hi, lo}, 1'b0, 1'b1, fw[2:0]});
  endtask

  // Monitor and stack-memory responder.
  initial begin
    logic prev_busy, prev_load, prev_pop_hs;
    prev_busy = 1'b0; prev_load = 1'b0; prev_pop_hs = 1'b0;
    pop_word = 16'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0; prev_load = 1'b0; prev_pop_hs = 1'b0;
        pop_word  = 16'h0;
      end else begin
        if (prev_pop_hs && pop_q.size() > 0) void'(pop_q.pop_front());
        chk("push_pop_exclusive", mem_push & mem_pop, 1'b0);
        chk("stall_tracks_busy", stall_fetch ^ busy, 1'b0);
        chk("pc_load_single", pc_load & prev_load, 1'b0);
        chk("flush_first_cycle", flush_decode, busy & ~prev_busy);
        chk("ack_restore_with_load", (int_ack | flags_restore_en) & ~pc_load, 1'b0);
        if (mem_push && mem_ready)
          take_ev("push_word", '{1'b0, {16'h0, push_data}, 1'b0, 1'b0, 3'b0});
        if (pc_load) begin
          take_ev("pc_load", '{1'b1, pc_load_value, int_ack, flags_restore_en, flags_restore});
          load_cyc = cyc;
          if (int_ack) ack_cyc = cyc;
        end
        prev_busy   = busy;
        prev_load   = pc_load;
        prev_pop_hs = mem_pop & mem_ready;
        pop_word    = (pop_q.size() > 0) ? pop_q[0] : 16'h0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      pipe_busy = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      @(negedge clk);
      if (!busy && sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout, busy=%b events outstanding=%0d", name, busy, sb.size());
  endtask

  function automatic logic [63:0] all_outs();
    return {6'h0, stall_fetch, flush_decode, mem_push, mem_pop, push_data, pc_load,
            pc_load_value, flags_restore_en, flags_restore, int_ack, busy};
  endfunction

  initial begin
    logic [15:0] w0, w1, w2;
    reset = 1'b1; int_req = 1'b0; rti_decoded = 1'b0; pipe_busy = 1'b0;
    mem_ready = 1'b1; pc_next = 32'h0; flags_in = 3'b0;
    #3;
    chk("reset_outputs", all_outs(), 64'h0);
    step(); step();
    reset = 1'b0;

    // Minimum-latency interrupt entry.
    pc_next = 32'h0001_2345; flags_in = 3'b101;
    step(); expect_int(pc_next, flags_in); int_req = 1'b1; edge_cyc = cyc + 1;
    step(); int_req = 1'b0;
    wait_done("int_entry", 50);
    chk("int_latency", ack_cyc - edge_cyc, 5);

    // Three drain cycles plus two stalled PUSH_LO cycles.
    step(); expect_int(pc_next, flags_in); int_req = 1'b1; pipe_busy = 1'b1; edge_cyc = cyc + 1;
    step(); int_req = 1'b0;
    step(); step(); step();
    step(); pipe_busy = 1'b0;
    step();
    step(); mem_ready = 1'b0;
    @(negedge clk); chk("push_lo_hold_a", {mem_push, push_data}, {1'b1, 16'h2345});
    step();
    @(negedge clk); chk("push_lo_hold_b", {mem_push, push_data}, {1'b1, 16'h2345});
    step(); mem_ready = 1'b1;
    wait_done("drain_backpressure", 50);
    chk("int_latency_stalled", ack_cyc - edge_cyc, 10);

    // RTI return.
    step(); expect_rti(16'h0006, 16'hBEEF, 16'h00AB); rti_decoded = 1'b1; edge_cyc = cyc + 1;
    step(); rti_decoded = 1'b0;
    wait_done("rti_return", 50);
    chk("rti_length", load_cyc - edge_cyc + 1, 5);

    // RTI seen in the same IDLE cycle where the new pending is visible: interrupt wins.
    pc_next = 32'h8000_0040; flags_in = 3'b010;
    step(); expect_int(pc_next, flags_in); int_req = 1'b1;
    step(); rti_decoded = 1'b1;
    step(); rti_decoded = 1'b0; int_req = 1'b0;
    wait_done("int_over_rti", 50);

    // Second edge during PUSH_HI runs after an IDLE cycle with fresh PC/flags.
    pc_next = 32'h0000_7777; flags_in = 3'b011;
    step(); expect_int(pc_next, flags_in); int_req = 1'b1;
    step(); int_req = 1'b0;
    step();
    step(); int_req = 1'b1; pc_next = 32'h1234_0010; flags_in = 3'b100;
    step(); int_req = 1'b0;
    wait_done("first_of_two", 50);
    expect_int(32'h1234_0010, 3'b100);
    step();
    @(negedge clk); chk("second_started", busy, 1'b1);
    wait_done("second_of_two", 50);

    // Reset in PUSH_LO with another interrupt pending: nothing resumes afterwards.
    pc_next = 32'hCAFE_F00D; flags_in = 3'b001;
    step(); expect_int(pc_next, flags_in); int_req = 1'b1;
    step(); int_req = 1'b0;
    step();
    step(); int_req = 1'b1;
    step(); int_req = 1'b0; mem_ready = 1'b0;
    step();
    @(negedge clk); chk("in_push_lo", {mem_push, push_data}, {1'b1, 16'hF00D});
    #2; reset = 1'b1; sb.delete(); pop_q.delete();
    #1; chk("reset_mid_seq_outputs", all_outs(), 64'h0);
    step(); step();
    reset = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk); chk("idle_after_reset", busy, 1'b0);
    end

    // Randomized sequences with random drain and stack backpressure.
    rand_mode = 1'b1;
    for (int t = 0; t < 100; t++) begin
      step();
      if ($urandom_range(0, 1) == 1) begin
        pc_next = $urandom; flags_in = 3'($urandom_range(0, 7));
        expect_int(pc_next, flags_in); int_req = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        int_req = 1'b0;
      end else begin
        w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
        expect_rti(w0, w1, w2); rti_decoded = 1'b1;
        step(); rti_decoded = 1'b0;
      end
      wait_done("random_seq", 200);
    end
    rand_mode = 1'b0; pipe_busy = 1'b0; mem_ready = 1'b1;
    step(); step();

    chk("scoreboard_drained", sb.size(), 0);
    chk("pop_words_consumed", pop_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1);
  end

endmodule
